// File: rtl/mul_pkg.sv
// Shared definitions for the iterative multiply sequencer: FSM encoding and iteration count.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_e;

  localparam int         MUL_ITER = 32;
  localparam logic [5:0] LAST_CNT = 6'(MUL_ITER - 1);

endpackage

// File: rtl/mul_signfix.sv
// Signed-multiply helper: operand magnitudes (33 bits so -2^31 fits), result sign, final negate.
// Purely combinational; only instantiated when SIGNED_MUL_EN is defined.
module mul_signfix
  import mul_pkg::*;
(
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        is_unsigned,
  input  logic        neg,
  input  logic [63:0] prod_raw,
  output logic [32:0] mag_a,
  output logic [32:0] mag_b,
  output logic        sign,
  output logic [63:0] prod
);

  logic neg_a;
  logic neg_b;

  assign neg_a = !is_unsigned && src_a[31];
  assign neg_b = !is_unsigned && src_b[31];

  // Sign-extend before negating so that -2^31 yields +2^31, not an overflowed value.
  assign mag_a = neg_a ? (33'd0 - {src_a[31], src_a}) : {1'b0, src_a};
  assign mag_b = neg_b ? (33'd0 - {src_b[31], src_b}) : {1'b0, src_b};
  assign sign  = neg_a ^ neg_b;

  assign prod  = neg ? (64'd0 - prod_raw) : prod_raw;

endmodule

// File: rtl/mul_sequencer.sv
// 32-iteration shift-add multiplier for the Execute stage; MulDone 33 cycles after StartE.
// Optional signed support is enabled by defining SIGNED_MUL_EN.
module mul_sequencer
  import mul_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        StartE,
  input  logic        LongE,
  input  logic        UnsignedE,
  input  logic        FlushE,
  input  logic [31:0] SrcAE,
  input  logic [31:0] SrcBE,
  output logic        StallMul,
  output logic        MulDone,
  output logic [31:0] MulLo,
  output logic [31:0] MulHi
);

  mul_state_e  state, state_nxt;
  logic        start_ok;
  logic [5:0]  cnt;
  logic [63:0] acc, acc_nxt, mcand, prod;
  logic [32:0] mplier, mag_a, mag_b;
  logic        long_q;

  assign acc_nxt = acc + (mplier[0] ? mcand : 64'd0);

`ifdef SIGNED_MUL_EN
  logic sign_in;
  logic sign_q;

  mul_signfix u_signfix (
    .src_a       (SrcAE),
    .src_b       (SrcBE),
    .is_unsigned (UnsignedE),
    .neg         (sign_q),
    .prod_raw    (acc_nxt),
    .mag_a       (mag_a),
    .mag_b       (mag_b),
    .sign        (sign_in),
    .prod        (prod)
  );

  always_ff @(posedge clk) begin
    if (reset)         sign_q <= 1'b0;
    else if (start_ok) sign_q <= sign_in;
  end
`else
  logic unused_unsigned;
  assign unused_unsigned = UnsignedE;
  assign mag_a = {1'b0, SrcAE};
  assign mag_b = {1'b0, SrcBE};
  assign prod  = acc_nxt;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Flush drops the stall in the same cycle so the pipeline is not held for a dead op.
  always_comb begin
    state_nxt = state;
    StallMul  = 1'b0;
    MulDone   = 1'b0;
    start_ok  = 1'b0;
    case (state)
      IDLE: begin
        if (StartE && !FlushE) begin
          state_nxt = RUN;
          StallMul  = 1'b1;
          start_ok  = 1'b1;
        end
      end
      RUN: begin
        if (FlushE) begin
          state_nxt = IDLE;
        end else begin
          StallMul = 1'b1;
          if (cnt == LAST_CNT) state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
        MulDone   = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
    if (reset) begin
      StallMul = 1'b0;
      MulDone  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      long_q <= 1'b0;
      MulLo  <= '0;
      MulHi  <= '0;
    end else if (start_ok) begin
      cnt    <= '0;
      acc    <= '0;
      mcand  <= {31'd0, mag_a};
      mplier <= mag_b;
      long_q <= LongE;
    end else if (state == RUN && !FlushE) begin
      cnt    <= cnt + 6'd1;
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      // Result is captured on the last iteration so it is stable throughout DONE.
      if (cnt == LAST_CNT) begin
        MulLo <= prod[31:0];
        MulHi <= long_q ? prod[63:32] : 32'd0;
      end
    end
  end

endmodule

// File: tb/tb_mul_sequencer.sv
// Scoreboard bench for mul_sequencer: directed vectors, expected results queued at issue time.
`timescale 1ns/1ps
module tb_mul_sequencer;

  logic        clk = 1'b0;
  logic        reset, StartE, LongE, UnsignedE, FlushE;
  logic [31:0] SrcAE, SrcBE;
  logic        StallMul, MulDone;
  logic [31:0] MulLo, MulHi;

`ifdef SIGNED_MUL_EN
  localparam bit SGN = 1'b1;
`else
  localparam bit SGN = 1'b0;
`endif

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    int          start;
  } exp_t;

  exp_t exp_q[$];
  int   tests_run    = 0;
  int   tests_failed = 0;
  int   cyc          = 0;

  mul_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .StartE    (StartE),
    .LongE     (LongE),
    .UnsignedE (UnsignedE),
    .FlushE    (FlushE),
    .SrcAE     (SrcAE),
    .SrcBE     (SrcBE),
    .StallMul  (StallMul),
    .MulDone   (MulDone),
    .MulLo     (MulLo),
    .MulHi     (MulHi)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (MulDone === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL spurious_done: MulDone=1 with nothing expected (cycle %0d)", cyc);
      end else begin
        e = exp_q.pop_front();
        check("mul_lo", {32'd0, MulLo}, {32'd0, e.lo});
        check("mul_hi", {32'd0, MulHi}, {32'd0, e.hi});
        check("latency", 64'(cyc - e.start), 64'd33);
      end
    end
  end

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic lng,
                        input logic uns, input logic [31:0] elo, input logic [31:0] ehi);
    int stall_cnt;
    bit seen;
    stall_cnt = 0;
    seen      = 1'b0;
    @(posedge clk); #1;
    SrcAE = a; SrcBE = b; LongE = lng; UnsignedE = uns; StartE = 1'b1;
    exp_q.push_back('{lo: elo, hi: ehi, start: cyc});
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (MulDone === 1'b1) begin
        seen = 1'b1;
        check("stall_in_done", {63'd0, StallMul}, 64'd0);
      end else if (StallMul === 1'b1) begin
        stall_cnt++;
      end
      @(posedge clk); #1;
      StartE = 1'b0;
    end
    if (!seen) begin
      tests_run++;
      tests_failed++;
      $display("FAIL done_timeout: MulDone not seen within 40 cycles (a=0x%0h b=0x%0h)", a, b);
    end
    check("stall_cycles", 64'(stall_cnt), 64'd33);
  endtask

  initial begin
    int stall_seen;
    reset = 1'b1; StartE = 1'b0; LongE = 1'b0; UnsignedE = 1'b0; FlushE = 1'b0;
    SrcAE = '0; SrcBE = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_lo", {32'd0, MulLo}, 64'd0);
    check("rst_hi", {32'd0, MulHi}, 64'd0);
    check("rst_done", {63'd0, MulDone}, 64'd0);
    check("rst_stall", {63'd0, StallMul}, 64'd0);

    run_op(32'd3, 32'd5, 1'b0, 1'b1, 32'h0000000F, 32'h0);

    // Flush at RUN iteration 10 (cycle 11 after StartE).
    @(posedge clk); #1;
    SrcAE = 32'd7; SrcBE = 32'd9; LongE = 1'b0; UnsignedE = 1'b1; StartE = 1'b1;
    @(posedge clk); #1 StartE = 1'b0;
    repeat (10) @(posedge clk);
    #1 FlushE = 1'b1;
    @(negedge clk);
    check("stall_flush_cycle", {63'd0, StallMul}, 64'd0);
    @(posedge clk); #1 FlushE = 1'b0;
    @(negedge clk);
    check("flush_stall_next", {63'd0, StallMul}, 64'd0);
    check("flush_lo_kept", {32'd0, MulLo}, 64'h0F);
    check("flush_hi_kept", {32'd0, MulHi}, 64'h0);
    stall_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (StallMul === 1'b1) stall_seen++;
    end
    check("flush_idle_stall", 64'(stall_seen), 64'd0);

    // FlushE and StartE together in IDLE: no start.
    @(posedge clk); #1;
    StartE = 1'b1; FlushE = 1'b1;
    @(negedge clk);
    check("idle_flush_stall", {63'd0, StallMul}, 64'd0);
    @(posedge clk); #1 StartE = 1'b0; FlushE = 1'b0;
    stall_seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (StallMul === 1'b1) stall_seen++;
    end
    check("idle_flush_nostart", 64'(stall_seen), 64'd0);

    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 32'h00000001, 32'hFFFFFFFE);
    run_op(32'hFFFFFFFE, 32'd3, 1'b1, 1'b0, 32'hFFFFFFFA, SGN ? 32'hFFFFFFFF : 32'h00000002);
    run_op(32'h80000000, 32'h80000000, 1'b1, 1'b0, 32'h0, 32'h40000000);
    run_op(32'hFFFFFFF9, 32'hFFFFFFFA, 1'b1, 1'b0, 32'd42, SGN ? 32'h0 : 32'hFFFFFFF3);
    run_op(32'hFFFFFFFE, 32'd3, 1'b0, 1'b0, 32'hFFFFFFFA, 32'h0);
    run_op(32'hFFFFFFFE, 32'd3, 1'b1, 1'b1, 32'hFFFFFFFA, 32'h00000002);
    run_op(32'h12345678, 32'h10, 1'b1, 1'b1, 32'h23456780, 32'h00000001);

    // Reset at RUN iteration 20 aborts the op and clears the registered outputs.
    @(posedge clk); #1;
    SrcAE = 32'h0000FFFF; SrcBE = 32'h0000FFFF; LongE = 1'b1; UnsignedE = 1'b1; StartE = 1'b1;
    @(posedge clk); #1 StartE = 1'b0;
    repeat (20) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("stall_in_reset", {63'd0, StallMul}, 64'd0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("midrun_rst_lo", {32'd0, MulLo}, 64'd0);
    check("midrun_rst_hi", {32'd0, MulHi}, 64'd0);
    check("midrun_rst_done", {63'd0, MulDone}, 64'd0);
    check("midrun_rst_stall", {63'd0, StallMul}, 64'd0);

    run_op(32'd7, 32'd6, 1'b0, 1'b1, 32'd42, 32'h0);

    repeat (5) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
